// File: rtl/mem_port_arbiter_if.sv
// Core-side and RAM-side bus bundle for mem_port_arbiter.
// slave: the arbiter's view; master: the core plus RAM environment view.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 6
);
  logic          if_req_i;
  logic [31:0]   if_addr_i;
  logic          if_gnt_o;
  logic          if_rvalid_o;
  logic [31:0]   if_rdata_o;

  logic          d_req_i;
  logic          d_we_i;
  logic [3:0]    d_wmask_i;
  logic [31:0]   d_addr_i;
  logic [31:0]   d_wdata_i;
  logic          d_gnt_o;
  logic          d_rvalid_o;
  logic [31:0]   d_rdata_o;

  logic          mem_en_o;
  logic          mem_we_o;
  logic [3:0]    mem_wmask_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [31:0]   mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_we_i, d_wmask_i, d_addr_i, d_wdata_i,
    input  mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_en_o, mem_we_o, mem_wmask_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output d_req_i, d_we_i, d_wmask_i, d_addr_i, d_wdata_i,
    output mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_en_o, mem_we_o, mem_wmask_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous-read RAM between the fetch and data ports.
// Data has fixed priority; one grant per cycle; 1-cycle read latency with
// per-port read-data hold registers.
// Optional: define MEM_PORT_ARB_STARVE_GUARD_EN to force a fetch grant after
// STARVE_LIMIT consecutive denied fetch cycles.
module mem_port_arbiter #(
  parameter int unsigned AW           = 6,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RD_IF = 2'd1;
  localparam logic [1:0] ST_RD_D  = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [31:0]   r_if_hold;
  logic [31:0]   r_d_hold;
  logic          w_if_gnt;
  logic          w_d_gnt;
  logic          w_force_if;
  logic          w_mem_en;
  logic          w_mem_we;
  logic [3:0]    w_mem_wmask;
  logic [AW-1:0] w_mem_addr;
  logic [31:0]   w_mem_wdata;

`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [CNT_W-1:0] r_starve_cnt;

  assign w_force_if = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  // Count consecutive denied fetch cycles, saturating at the limit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_starve_cnt <= '0;
    end else if (bus.if_req_i && !w_if_gnt) begin
      if (!w_force_if) r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end else begin
      r_starve_cnt <= '0;
    end
  end
`else
  logic [31:0] w_unused_limit;

  assign w_force_if     = 1'b0;
  assign w_unused_limit = 32'(STARVE_LIMIT);
`endif

  logic w_unused_addr;
  assign w_unused_addr = ^{bus.if_addr_i[31:AW+2], bus.if_addr_i[1:0],
                           bus.d_addr_i[31:AW+2], bus.d_addr_i[1:0]};

  // Fixed-priority grant (data first); everything reads 0 while in reset.
  always_comb begin
    w_d_gnt  = 1'b0;
    w_if_gnt = 1'b0;
    if (rst_ni) begin
      w_d_gnt  = bus.d_req_i & ~(w_force_if & bus.if_req_i);
      w_if_gnt = bus.if_req_i & ~w_d_gnt;
    end
  end

  // RAM-side drive from whichever port holds the grant.
  always_comb begin
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_wmask = '0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (w_d_gnt) begin
      w_mem_en    = 1'b1;
      w_mem_we    = bus.d_we_i;
      w_mem_wmask = bus.d_wmask_i;
      w_mem_addr  = bus.d_addr_i[AW+1:2];
      w_mem_wdata = bus.d_wdata_i;
    end else if (w_if_gnt) begin
      w_mem_en    = 1'b1;
      w_mem_addr  = bus.if_addr_i[AW+1:2];
    end
  end

  // Next in-flight state: which port (if any) gets read data next cycle.
  always_comb begin
    w_state_nxt = ST_IDLE;
    if (w_if_gnt) begin
      w_state_nxt = ST_RD_IF;
    end else if (w_d_gnt && !bus.d_we_i) begin
      w_state_nxt = ST_RD_D;
    end
  end

  // In-flight state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Hold registers keep the last returned word per port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_if_hold <= '0;
      r_d_hold  <= '0;
    end else begin
      if (r_state == ST_RD_IF) r_if_hold <= bus.mem_rdata_i;
      if (r_state == ST_RD_D)  r_d_hold  <= bus.mem_rdata_i;
    end
  end

  assign bus.if_gnt_o    = w_if_gnt;
  assign bus.d_gnt_o     = w_d_gnt;
  assign bus.mem_en_o    = w_mem_en;
  assign bus.mem_we_o    = w_mem_we;
  assign bus.mem_wmask_o = w_mem_wmask;
  assign bus.mem_addr_o  = w_mem_addr;
  assign bus.mem_wdata_o = w_mem_wdata;

  assign bus.if_rvalid_o = (r_state == ST_RD_IF);
  assign bus.d_rvalid_o  = (r_state == ST_RD_D);
  assign bus.if_rdata_o  = (r_state == ST_RD_IF) ? bus.mem_rdata_i : r_if_hold;
  assign bus.d_rdata_o   = (r_state == ST_RD_D)  ? bus.mem_rdata_i : r_d_hold;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences for
// starvation and reset-during-read, then constrained-random traffic checked
// against a transaction-level model (shadow memory + pending response).
module tb_mem_port_arbiter;

  localparam int unsigned AW    = 6;
  localparam int unsigned NW    = 64;
  localparam int          LIMIT = 4;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_wmask;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
  } ins_t;

  typedef struct {
    logic          if_gnt;
    logic          d_gnt;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_wmask;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
  } outs_t;

  typedef struct {
    ins_t  stim;
    outs_t want;
  } vec_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  logic ram_clear = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter_if #(.AW(AW)) bus ();

  mem_port_arbiter #(.AW(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] init_word(input int i);
    if (i == 3) return 32'h0050_0093;
    if (i == 8) return 32'h1122_3344;
    return {16'hC0DE, 8'(i), 8'(i) ^ 8'h5A};
  endfunction

  // RAM environment: synchronous read, byte-masked write.
  logic [31:0] ram [NW];
  always @(posedge clk_i) begin
    if (ram_clear) begin
      for (int i = 0; i < int'(NW); i++) ram[i] <= init_word(i);
      bus.mem_rdata_i <= 32'h0;
    end else if (bus.mem_en_o) begin
      if (bus.mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_wmask_o[b]) ram[bus.mem_addr_o][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
      end else begin
        bus.mem_rdata_i <= ram[bus.mem_addr_o];
      end
    end
  end

  function automatic ins_t mk_in(input logic ir, input logic [31:0] ia, input logic dr,
                                 input logic dw, input logic [3:0] dm,
                                 input logic [31:0] da, input logic [31:0] dd);
    ins_t t;
    t.if_req = ir; t.if_addr = ia; t.d_req = dr; t.d_we = dw;
    t.d_wmask = dm; t.d_addr = da; t.d_wdata = dd;
    return t;
  endfunction

  function automatic outs_t mk_out(input logic ig, input logic dg, input logic en,
                                   input logic we, input logic [3:0] wm,
                                   input logic [AW-1:0] ma, input logic [31:0] wd,
                                   input logic irv, input logic [31:0] ird,
                                   input logic drv, input logic [31:0] drd);
    outs_t o;
    o.if_gnt = ig; o.d_gnt = dg; o.mem_en = en; o.mem_we = we; o.mem_wmask = wm;
    o.mem_addr = ma; o.mem_wdata = wd; o.if_rvalid = irv; o.if_rdata = ird;
    o.d_rvalid = drv; o.d_rdata = drd;
    return o;
  endfunction

  task automatic apply(input ins_t s);
    bus.if_req_i  = s.if_req;
    bus.if_addr_i = s.if_addr;
    bus.d_req_i   = s.d_req;
    bus.d_we_i    = s.d_we;
    bus.d_wmask_i = s.d_wmask;
    bus.d_addr_i  = s.d_addr;
    bus.d_wdata_i = s.d_wdata;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic compare(input outs_t w, input string tag);
    chk({tag, ".if_gnt"},    32'(bus.if_gnt_o),    32'(w.if_gnt));
    chk({tag, ".d_gnt"},     32'(bus.d_gnt_o),     32'(w.d_gnt));
    chk({tag, ".mem_en"},    32'(bus.mem_en_o),    32'(w.mem_en));
    chk({tag, ".mem_we"},    32'(bus.mem_we_o),    32'(w.mem_we));
    chk({tag, ".mem_wmask"}, 32'(bus.mem_wmask_o), 32'(w.mem_wmask));
    chk({tag, ".mem_addr"},  32'(bus.mem_addr_o),  32'(w.mem_addr));
    chk({tag, ".mem_wdata"}, bus.mem_wdata_o,      w.mem_wdata);
    chk({tag, ".if_rvalid"}, 32'(bus.if_rvalid_o), 32'(w.if_rvalid));
    chk({tag, ".if_rdata"},  bus.if_rdata_o,       w.if_rdata);
    chk({tag, ".d_rvalid"},  32'(bus.d_rvalid_o),  32'(w.d_rvalid));
    chk({tag, ".d_rdata"},   bus.d_rdata_o,        w.d_rdata);
    if (bus.if_gnt_o && bus.d_gnt_o) chk({tag, ".one_gnt"}, 32'd2, 32'd1);
    if (bus.if_rvalid_o && bus.d_rvalid_o) chk({tag, ".one_rvalid"}, 32'd2, 32'd1);
  endtask

  // Transaction-level reference model.
  logic [31:0] sh [NW];
  logic [31:0] m_if_hold, m_d_hold, m_pend_data;
  int          m_pend;    // 0 none, 1 fetch response due, 2 load response due
  int          m_starve;

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % NW);
  endfunction

  task automatic model_init();
    for (int i = 0; i < int'(NW); i++) sh[i] = init_word(i);
    m_if_hold = 32'h0; m_d_hold = 32'h0; m_pend_data = 32'h0;
    m_pend = 0; m_starve = 0;
  endtask

  task automatic model_eval(input ins_t s, output outs_t o);
    logic force_if;
    force_if = 1'b0;
`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
    force_if = (m_starve == LIMIT) && s.if_req;
`endif
    o.d_gnt     = s.d_req && !force_if;
    o.if_gnt    = s.if_req && !o.d_gnt;
    o.mem_en    = o.d_gnt || o.if_gnt;
    o.mem_we    = o.d_gnt && s.d_we;
    o.mem_wmask = o.d_gnt ? s.d_wmask : 4'h0;
    o.mem_wdata = o.d_gnt ? s.d_wdata : 32'h0;
    o.mem_addr  = o.d_gnt ? AW'(word_of(s.d_addr)) : (o.if_gnt ? AW'(word_of(s.if_addr)) : '0);
    o.if_rvalid = (m_pend == 1);
    o.d_rvalid  = (m_pend == 2);
    o.if_rdata  = (m_pend == 1) ? m_pend_data : m_if_hold;
    o.d_rdata   = (m_pend == 2) ? m_pend_data : m_d_hold;
  endtask

  task automatic model_commit(input ins_t s, input outs_t o);
    int w;
    if (m_pend == 1) m_if_hold = m_pend_data;
    if (m_pend == 2) m_d_hold  = m_pend_data;
    m_pend = 0;
    if (o.if_gnt) begin
      m_pend = 1; m_pend_data = sh[word_of(s.if_addr)];
    end else if (o.d_gnt && !s.d_we) begin
      m_pend = 2; m_pend_data = sh[word_of(s.d_addr)];
    end else if (o.d_gnt) begin
      w = word_of(s.d_addr);
      for (int b = 0; b < 4; b++)
        if (s.d_wmask[b]) sh[w][8*b +: 8] = s.d_wdata[8*b +: 8];
    end
    if (s.if_req && !o.if_gnt) m_starve = (m_starve < LIMIT) ? m_starve + 1 : m_starve;
    else                       m_starve = 0;
  endtask

  ins_t  idle_in;
  outs_t zero_o;

  task automatic do_reset(input string tag);
    @(negedge clk_i);
    rst_ni = 1'b0; ram_clear = 1'b1;
    apply(mk_in(1'b1, 32'h0C, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0));
    #1 compare(zero_o, tag);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1; ram_clear = 1'b0;
    apply(idle_in);
    model_init();
  endtask

  vec_t  vq [$];
  vec_t  v;
  outs_t e;
  ins_t  cur;
  logic  g_if, g_d;
  int    dprob;

  initial begin
    idle_in = mk_in(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    zero_o  = mk_out(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 6'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    apply(idle_in);

    // Directed table: fetch, masked store/load, contention, address wrap.
    v.stim = idle_in;                                                       v.want = zero_o; vq.push_back(v);
    v.stim = mk_in(1, 32'h0C, 0, 0, 4'h0, 32'h0, 32'h0);
    v.want = mk_out(1, 0, 1, 0, 4'h0, 6'd3, 32'h0, 0, 32'h0, 0, 32'h0);      vq.push_back(v);
    v.stim = idle_in;
    v.want = mk_out(0, 0, 0, 0, 4'h0, 6'd0, 32'h0, 1, 32'h00500093, 0, 32'h0); vq.push_back(v);
    v.want = mk_out(0, 0, 0, 0, 4'h0, 6'd0, 32'h0, 0, 32'h00500093, 0, 32'h0); vq.push_back(v);
    v.stim = mk_in(0, 32'h0, 1, 1, 4'b0010, 32'h20, 32'h0000AB00);
    v.want = mk_out(0, 1, 1, 1, 4'h2, 6'd8, 32'h0000AB00, 0, 32'h00500093, 0, 32'h0); vq.push_back(v);
    v.stim = mk_in(0, 32'h0, 1, 0, 4'h0, 32'h20, 32'h0);
    v.want = mk_out(0, 1, 1, 0, 4'h0, 6'd8, 32'h0, 0, 32'h00500093, 0, 32'h0); vq.push_back(v);
    v.stim = idle_in;
    v.want = mk_out(0, 0, 0, 0, 4'h0, 6'd0, 32'h0, 0, 32'h00500093, 1, 32'h1122AB44); vq.push_back(v);
    v.stim = mk_in(1, 32'h0C, 1, 0, 4'h0, 32'h10C, 32'h0);
    v.want = mk_out(0, 1, 1, 0, 4'h0, 6'd3, 32'h0, 0, 32'h00500093, 0, 32'h1122AB44); vq.push_back(v);
    v.stim = mk_in(1, 32'h0C, 0, 0, 4'h0, 32'h0, 32'h0);
    v.want = mk_out(1, 0, 1, 0, 4'h0, 6'd3, 32'h0, 0, 32'h00500093, 1, 32'h00500093); vq.push_back(v);
    v.stim = mk_in(1, 32'hFFFFFF23, 0, 0, 4'h0, 32'h0, 32'h0);
    v.want = mk_out(1, 0, 1, 0, 4'h0, 6'd8, 32'h0, 1, 32'h00500093, 0, 32'h00500093); vq.push_back(v);
    v.stim = idle_in;
    v.want = mk_out(0, 0, 0, 0, 4'h0, 6'd0, 32'h0, 1, 32'h1122AB44, 0, 32'h00500093); vq.push_back(v);
    v.want = mk_out(0, 0, 0, 0, 4'h0, 6'd0, 32'h0, 0, 32'h1122AB44, 0, 32'h00500093); vq.push_back(v);

    do_reset("reset");
    foreach (vq[i]) begin
      @(negedge clk_i);
      apply(vq[i].stim);
      #1 compare(vq[i].want, $sformatf("vec%0d", i));
    end

    // Data load stream held for 10 cycles against a pending fetch.
    for (int k = 1; k <= 10; k++) begin
      logic exp_if;
      @(negedge clk_i);
      apply(mk_in(1'b1, 32'h0, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0));
      exp_if = 1'b0;
`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
      exp_if = (k % 5 == 0);
`endif
      #1;
      chk($sformatf("starve%0d.if_gnt", k), 32'(bus.if_gnt_o), 32'(exp_if));
      chk($sformatf("starve%0d.d_gnt", k),  32'(bus.d_gnt_o),  32'(!exp_if));
    end
    @(negedge clk_i); apply(idle_in);
    @(negedge clk_i);

    // Reset asserted right after a fetch grant drops the response.
    @(negedge clk_i);
    apply(mk_in(1'b1, 32'h0C, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0));
    #1 chk("mid.if_gnt", 32'(bus.if_gnt_o), 32'd1);
    #1 rst_ni = 1'b0;
    #1 compare(zero_o, "mid_rst");
    @(negedge clk_i);
    apply(idle_in);
    rst_ni = 1'b1;
    #1 compare(zero_o, "mid_rel");
    @(negedge clk_i);
    #1 compare(zero_o, "mid_rel2");

    // Random traffic obeying hold-until-grant, with data-heavy phases.
    do_reset("reset2");
    cur = idle_in; g_if = 1'b0; g_d = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!cur.if_req || g_if) begin
        cur.if_req  = ($urandom_range(99) < 55);
        cur.if_addr = $urandom;
      end
      dprob = ((c / 64) % 2 == 1) ? 92 : 45;
      if (!cur.d_req || g_d) begin
        cur.d_req   = ($urandom_range(99) < dprob);
        cur.d_we    = 1'($urandom_range(1));
        cur.d_wmask = 4'($urandom);
        cur.d_addr  = $urandom;
        cur.d_wdata = $urandom;
      end
      @(negedge clk_i);
      apply(cur);
      model_eval(cur, e);
      #1 compare(e, $sformatf("rnd%0d", c));
      g_if = e.if_gnt;
      g_d  = e.d_gnt;
      model_commit(cur, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, synchronous-read, byte-maskable word RAM between the core's instruction-fetch port and data port.
- Fixed-priority arbitration, one grant per cycle, 1-cycle read latency, per-port read-data hold registers.
- Sits between the core's imem/dmem buses and a unified program/data RAM, for use in the planned multi-cycle / shared-memory core variant.

Parameters:
- AW, 6, word-address width of the RAM (64 words by default); byte address bits [AW+1:2] are used.
- STARVE_LIMIT, 4, consecutive denied fetch cycles before a fetch is forced (only with the optional feature).

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request (read-only)
- if_addr_i  in  32  fetch byte address
- if_gnt_o  out  1  fetch granted this cycle
- if_rvalid_o  out  1  fetch data valid
- if_rdata_o  out  32  fetch data
- d_req_i  in  1  data request
- d_we_i  in  1  1 = store, 0 = load
- d_wmask_i  in  4  byte-lane write enables
- d_addr_i  in  32  data byte address
- d_wdata_i  in  32  store data
- d_gnt_o  out  1  data granted this cycle
- d_rvalid_o  out  1  load data valid
- d_rdata_o  out  32  load data
- mem_en_o  out  1  RAM access strobe
- mem_we_o  out  1  RAM write enable
- mem_wmask_o  out  4  RAM byte-lane mask
- mem_addr_o  out  AW  RAM word address
- mem_wdata_o  out  32  RAM write data
- mem_rdata_i  in  32  RAM read data, valid the cycle after an enabled read

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
  - Reset clears all state, the starvation counter, and both hold registers.
  - All outputs read 0 during reset.
- Requester rules:
  - A requester holds req and its payload stable until it sees gnt high.
  - gnt is combinational from the current cycle's req and state.
  - The RAM samples mem_* on the same clock edge that ends the grant cycle.
- Arbitration:
  - d_req_i wins over if_req_i.
  - if_gnt_o = if_req_i & ~d_req_i.
  - At most one gnt is high per cycle.
  - With no requests, mem_en_o = 0 and all other mem_* outputs are 0.
- Memory-side drive on grant:
  - mem_en_o = 1.
  - mem_addr_o = granted addr[AW+1:2]; addr[1:0] is ignored.
  - Data grant: mem_we_o = d_we_i, mem_wmask_o = d_wmask_i, mem_wdata_o = d_wdata_i.
  - Fetch grant: mem_we_o = 0, mem_wmask_o = 0, mem_wdata_o = 0.
- In-flight state machine (registered), states IDLE, RD_IF, RD_D:
  - Next state is RD_IF after a fetch grant, RD_D after a data grant with d_we_i = 0, otherwise IDLE.
  - Transitions are evaluated every cycle, so back-to-back grants are allowed.
  - Sustained throughput is 1 access per cycle.
- Response:
  - In RD_IF, if_rvalid_o = 1 and if_rdata_o = mem_rdata_i; the hold register captures mem_rdata_i.
  - In RD_D, d_rvalid_o = 1 and d_rdata_o = mem_rdata_i; the data hold register captures mem_rdata_i.
  - Outside those states, each rdata_o shows its hold register, stable until that port's next rvalid.
  - Stores produce no rvalid.
- Boundary cases:
  - Simultaneous requests: data is granted; fetch stays pending and is granted on the first cycle d_req_i is low.
  - Request withdrawn before grant: protocol violation. Not checked; no state effect.
  - Reset asserted while in RD_IF or RD_D: the response is dropped and no rvalid is produced after release.
  - Addresses above the RAM range wrap modulo 2^AW words.

Optional Feature:
- Macro: MEM_PORT_ARB_STARVE_GUARD_EN.
- Defined:
  - A counter (width clog2(STARVE_LIMIT+1)) increments each cycle if_req_i = 1 and if_gnt_o = 0.
  - It clears on a fetch grant or when if_req_i = 0.
  - When the counter equals STARVE_LIMIT and both ports request, fetch is granted and data waits.
  - The counter saturates and never wraps.
- Undefined: pure fixed priority; a continuous data stream starves fetch indefinitely; the counter is absent.

Test Plan:
- Fetch only: RAM[3] = 32'h00500093, if_req_i = 1, if_addr_i = 32'h0C → if_gnt_o = 1 same cycle, mem_addr_o = 3; next cycle if_rvalid_o = 1, if_rdata_o = 32'h00500093, held after if_req_i drops.
- Masked store then load: store d_addr_i = 32'h20, d_wmask_i = 4'b0010, d_wdata_i = 32'h0000AB00 to RAM[8] = 32'h11223344 → no d_rvalid_o; following load of 32'h20 gives d_rvalid_o next cycle, d_rdata_o = 32'h1122AB44.
- Contention: if_req_i and a d_req_i load both high for one cycle → d_gnt_o = 1, if_gnt_o = 0; next cycle if_gnt_o = 1 and d_rvalid_o = 1; following cycle if_rvalid_o = 1; throughout, at most one gnt and one rvalid per cycle.
- Starvation, macro defined, STARVE_LIMIT = 4: d_req_i held high 10 cycles with if_req_i high → if_gnt_o in cycle 5, data denied that cycle, then data resumes.
- Starvation, macro undefined: same stimulus → if_gnt_o = 0 for all 10 cycles.
- Reset mid-read: fetch granted, rst_ni low before the next edge → if_rvalid_o = 0 and if_rdata_o = 0 after release, state IDLE, mem_en_o = 0.
